// File: rtl/eeg_sample_loader_pkg.sv
// Shared types and memory-map constants for the EEG front end.
// Holds the loader FSM state type and the sample offset used for sign conversion.
package eeg_sample_loader_pkg;

    localparam int NUM_PATCHES = 60;
    localparam int PATCH_LEN   = 64;

    typedef logic [15:0] AdcData_t;
    typedef logic [15:0] IntResAddr_t;
    typedef logic [15:0] IntResDouble_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic [1:0] {
        INT_RES_SW_FX = 2'd0,
        INT_RES_DW_FX = 2'd1
    } FxFormatIntRes_t;

    // Base address of each region in the intermediate-result memory.
    localparam int EEG_INPUT_MEM   = 0;
    localparam int NUM_MEM_REGIONS = 2;
    localparam IntResAddr_t mem_map [NUM_MEM_REGIONS] = '{16'h0000, 16'h0F00};

    localparam int EEG_FORMAT  = 0;
    localparam int NUM_FORMATS = 2;
    localparam FxFormatIntRes_t int_res_format [NUM_FORMATS] = '{INT_RES_DW_FX, INT_RES_SW_FX};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } LoaderState_t;

    // Offset-binary to two's complement is a flip of the MSB.
    localparam AdcData_t EEG_SAMPLE_OFFSET = 16'h8000;

endpackage

// File: rtl/eeg_sample_loader_sync_fifo.sv
// Small synchronous FIFO used as the skid buffer between the ADC and the memory port.
// Storage is reset so the head reads zero after reset.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // A push into a full FIFO is only legal when the head leaves this cycle.
            if (push && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eeg_sample_loader.sv
// Streams one epoch of ADC samples, sign-converted, into the intermediate-result memory.
// state | meaning: IDLE wait start | LOAD accept ADC | DRAIN flush FIFO | ERR overflow, wait start
module eeg_sample_loader
    import eeg_sample_loader_pkg::*;
#(
    parameter int NUM_SAMPLES = NUM_PATCHES * PATCH_LEN,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            adc_valid,
    input  AdcData_t        adc_data,
    output logic            mem_wr_req,
    input  logic            mem_wr_gnt,
    output IntResAddr_t     mem_addr,
    output IntResDouble_t   mem_data,
    output DataWidth_t      mem_width,
    output FxFormatIntRes_t mem_format,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    localparam int            CW   = $clog2(NUM_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

    LoaderState_t  state;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] wr_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_clear;
    logic          fifo_push;
    logic          push;
    logic          pop;
    logic          drop;
    IntResDouble_t fifo_rdata;

    assign push       = adc_valid && (state == LOAD);
    assign pop        = mem_wr_req && mem_wr_gnt;
    assign drop       = push && fifo_full && !pop;
    assign fifo_push  = push && !drop;
    assign fifo_clear = start && ((state == IDLE) || (state == ERR));

    // Data left behind by an overflow stays parked until the next start clears it.
    assign mem_wr_req = !fifo_empty && (state != ERR);
    assign mem_data   = fifo_rdata;
    assign mem_addr   = mem_map[EEG_INPUT_MEM] + IntResAddr_t'(wr_cnt);
    assign mem_width  = DOUBLE_WIDTH;
    assign mem_format = int_res_format[EEG_FORMAT];

    sync_fifo #(
        .WIDTH ($bits(IntResDouble_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (adc_data ^ EEG_SAMPLE_OFFSET),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                wr_cnt <= wr_cnt + CW'(1);
            end
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        acc_cnt  <= '0;
                        wr_cnt   <= '0;
                        overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (drop) begin
                        state    <= ERR;
                        busy     <= 1'b0;
                        overflow <= 1'b1;
                    end else if (push) begin
                        acc_cnt <= acc_cnt + CW'(1);
                        if (acc_cnt == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (wr_cnt == LAST)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eeg_sample_loader.sv
// Bench for eeg_sample_loader: queue-based epoch model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_eeg_sample_loader;
    import eeg_sample_loader_pkg::*;

    localparam int N     = 3840;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst;
    logic            start;
    logic            adc_valid;
    AdcData_t        adc_data;
    logic            mem_wr_req;
    logic            mem_wr_gnt;
    IntResAddr_t     mem_addr;
    IntResDouble_t   mem_data;
    DataWidth_t      mem_width;
    FxFormatIntRes_t mem_format;
    logic            busy;
    logic            done;
    logic            overflow;

    eeg_sample_loader #(.NUM_SAMPLES(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .mem_wr_req (mem_wr_req),
        .mem_wr_gnt (mem_wr_gnt),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_width  (mem_width),
        .mem_format (mem_format),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    bit chk_en;

    // Epoch model: a queue of pending converted samples plus progress counts.
    logic [15:0] q[$];
    int  m_wr, m_acc, sz;
    bit  m_active, m_loading, m_err, m_ovf, m_done, p_pop, p_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_wr = 0; m_acc = 0; m_active = 0; m_loading = 0;
            m_err = 0; m_ovf = 0; m_done = 0;
        end else begin
            sz     = q.size();
            p_pop  = mem_wr_gnt && (sz > 0) && !m_err;
            p_push = m_loading && adc_valid;
            m_done = 0;
            if (start && !m_active) begin
                q.delete();
                m_wr = 0; m_acc = 0; m_active = 1; m_loading = 1; m_err = 0; m_ovf = 0;
            end else if (p_push && (sz == DEPTH) && !p_pop) begin
                m_ovf = 1; m_err = 1; m_loading = 0; m_active = 0;
            end else begin
                if (p_pop) begin
                    void'(q.pop_front());
                    m_wr++;
                    if (m_wr == N) begin
                        m_done = 1;
                        m_active = 0;
                    end
                end
                if (p_push) begin
                    q.push_back(adc_data ^ 16'h8000);
                    m_acc++;
                    if (m_acc == N) m_loading = 0;
                end
            end
        end
    end

    logic        exp_req;
    logic [15:0] exp_data;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_req  = (q.size() > 0) && !m_err;
            exp_data = (q.size() > 0) ? q[0] : 16'h0000;
            n_tests++;
            if (mem_wr_req !== exp_req || mem_addr !== 16'(m_wr) ||
                (exp_req && mem_data !== exp_data) || busy !== m_active ||
                done !== m_done || overflow !== m_ovf ||
                mem_width !== DOUBLE_WIDTH || mem_format !== INT_RES_DW_FX) begin
                n_fail++;
                $display("FAIL cycle t=%0t got req=%b addr=%h data=%h busy=%b done=%b ovf=%b wid=%b fmt=%h exp req=%b addr=%h data=%h busy=%b done=%b ovf=%b",
                         $time, mem_wr_req, mem_addr, mem_data, busy, done, overflow, mem_width, mem_format,
                         exp_req, 16'(m_wr), exp_data, m_active, m_done, m_ovf);
            end
        end
    end

    // Log of accepted writes and done pulses for the scenario-level checks.
    int          wcount, dcount;
    logic [15:0] first_addr, last_addr;
    logic [15:0] dlog [3];
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_wr_req && mem_wr_gnt) begin
                if (wcount < 3) dlog[wcount] = mem_data;
                if (wcount == 0) first_addr = mem_addr;
                last_addr = mem_addr;
                wcount++;
            end
            if (done) dcount++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wcount = 0; dcount = 0; first_addr = 16'hFFFF; last_addr = 16'h0000;
        for (int i = 0; i < 3; i++) dlog[i] = 16'h1234;
    endtask

    task automatic do_start();
        start = 1; adc_valid = 0;
        tick();
        start = 0;
    endtask

    function automatic logic [15:0] smp(input int i, input int seed);
        logic [31:0] v;
        case (i)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: begin
                v = i * 40503 + seed * 977;
                return v[15:0];
            end
        endcase
    endfunction

    task automatic run_samples(input int n, input int gnt_low, input int mid_start, input int seed);
        for (int i = 0; i < n; i++) begin
            adc_valid  = 1;
            adc_data   = smp(i, seed);
            mem_wr_gnt = (i >= gnt_low);
            start      = (i == mid_start);
            tick();
        end
        adc_valid = 0; start = 0; mem_wr_gnt = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 0; rst = 1; start = 0; adc_valid = 0; adc_data = 0; mem_wr_gnt = 1;
        chk_en = 0; n_tests = 0; n_fail = 0;
        clear_log();
        #1;
        chk("reset_req",  mem_wr_req, 0);
        chk("reset_addr", mem_addr, 32'h0000);
        chk("reset_data", mem_data, 32'h0000);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovf",  overflow, 0);
        tick(); tick();
        rst = 0;
        tick();
        chk_en = 1;

        // Full epoch, grant tied high; first three samples pin the offset conversion.
        clear_log();
        do_start();
        run_samples(N, 0, -1, 1);
        repeat (6) tick();
        chk("s1_first_addr", first_addr, 32'd0);
        chk("s1_last_addr",  last_addr, 32'd3839);
        chk("s1_writes",     wcount, 32'd3840);
        chk("s1_done_count", dcount, 32'd1);
        chk("s1_ovf",        overflow, 0);
        chk("s2_data0", dlog[0], 32'h8000);
        chk("s2_data1", dlog[1], 32'h7FFF);
        chk("s2_data2", dlog[2], 32'h0000);

        // Grant withheld for two cycles: FIFO absorbs it.
        clear_log();
        do_start();
        run_samples(N, 2, -1, 2);
        repeat (6) tick();
        chk("s3_writes",     wcount, 32'd3840);
        chk("s3_last_addr",  last_addr, 32'd3839);
        chk("s3_done_count", dcount, 32'd1);
        chk("s3_ovf",        overflow, 0);

        // Grant withheld for three cycles: third push overflows.
        clear_log();
        do_start();
        run_samples(6, 3, -1, 3);
        tick();
        chk("s3b_ovf",    overflow, 1);
        chk("s3b_req",    mem_wr_req, 0);
        chk("s3b_busy",   busy, 0);
        chk("s3b_writes", wcount, 32'd0);
        chk("s3b_done",   dcount, 32'd0);

        // Restart out of the error state, then reset mid-epoch.
        clear_log();
        do_start();
        chk("s4_ovf_cleared", overflow, 0);
        chk("s4_busy",        busy, 1);
        run_samples(100, 0, -1, 4);
        rst = 1;
        #1;
        chk("s4_rst_req",  mem_wr_req, 0);
        chk("s4_rst_busy", busy, 0);
        chk("s4_rst_addr", mem_addr, 32'h0000);
        chk("s4_rst_data", mem_data, 32'h0000);
        chk("s4_rst_done", done, 0);
        tick(); tick();
        rst = 0;
        repeat (4) tick();
        chk("s4_no_done", dcount, 32'd0);

        // Stray samples around the epoch and a start pulse mid-load.
        clear_log();
        for (int i = 0; i < 5; i++) begin
            adc_valid = 1; adc_data = 16'(16'h1111 * (i + 1));
            tick();
        end
        adc_valid = 0;
        chk("s5_pre_writes", wcount, 32'd0);
        do_start();
        run_samples(N, 0, 1000, 5);
        for (int i = 0; i < 10; i++) begin
            adc_valid = 1; adc_data = 16'hABCD;
            tick();
        end
        adc_valid = 0;
        repeat (6) tick();
        chk("s5_first_addr", first_addr, 32'd0);
        chk("s5_last_addr",  last_addr, 32'd3839);
        chk("s5_writes",     wcount, 32'd3840);
        chk("s6_done_count", dcount, 32'd1);
        chk("s6_ovf",        overflow, 0);
        chk("s6_busy_idle",  busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eeg_sample_loader.md
EEG_SAMPLE_LOADER -- requirements
Module: eeg_sample_loader

Interface
REQ-001 Parameter NUM_SAMPLES, default NUM_PATCHES*PATCH_LEN (3840): samples per EEG epoch.
REQ-002 Parameter FIFO_DEPTH, default 2: skid buffer depth, power of two, minimum 2.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse from the top FSM on the IDLE_CIM to EEG_LOAD transition.
REQ-006 Port adc_valid, input, 1: adc_data holds a new sample this cycle; there is no backpressure to the ADC.
REQ-007 Port adc_data, input, AdcData_t (16): unsigned offset-binary ADC sample.
REQ-008 Port mem_wr_req, output, 1: write request to the intermediate-result memory.
REQ-009 Port mem_wr_gnt, input, 1: memory accepts the request this cycle.
REQ-010 Port mem_addr, output, IntResAddr_t: write address.
REQ-011 Port mem_data, output, IntResDouble_t (16): write data.
REQ-012 Port mem_width, output, DataWidth_t: constant DOUBLE_WIDTH.
REQ-013 Port mem_format, output, FxFormatIntRes_t: int_res_format[EEG_FORMAT] (INT_RES_DW_FX).
REQ-014 Port busy, output, 1: high in LOAD and DRAIN.
REQ-015 Port done, output, 1: one-cycle pulse when the final sample is granted.
REQ-016 Port overflow, output, 1: sticky error flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, DRAIN and ERR; the encoding belongs to the package.
REQ-018 IDLE transitions to LOAD on start, clearing the accept counter, the write counter, the FIFO and overflow.
REQ-019 In LOAD, each adc_valid cycle pushes (adc_data ^ 16'h8000) into the FIFO and increments the accept counter.
REQ-020 When the accept counter reaches NUM_SAMPLES, the FSM SHALL go to DRAIN, and adc_valid is ignored from that point.
REQ-021 In IDLE, DRAIN and ERR, adc_valid SHALL be ignored and not counted.
REQ-022 mem_wr_req SHALL equal FIFO-not-empty, mem_data the FIFO head, and mem_addr mem_map[EEG_INPUT_MEM] + write counter (stride 1).
REQ-023 A grant in a cycle with mem_wr_req high SHALL pop the FIFO and increment the write counter.
REQ-024 A grant while mem_wr_req is low SHALL be ignored.
REQ-025 A push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-026 A push into a full FIFO with no simultaneous pop SHALL drop the sample, set overflow, and move the FSM to ERR.
REQ-027 ERR holds mem_wr_req low, leaves busy low, and exits to IDLE only on start, which clears overflow and begins LOAD.
REQ-028 On the grant of write NUM_SAMPLES-1, done SHALL pulse on the next cycle and the FSM SHALL go to IDLE.
REQ-029 Latency from an adc_valid push into an empty FIFO to mem_wr_req is 1 cycle.
REQ-030 start asserted while in LOAD or DRAIN SHALL be ignored.
REQ-031 Both counters are $clog2(NUM_SAMPLES+1) bits wide and never wrap within an epoch.

Reset
REQ-032 Asserting rst SHALL immediately set the FSM to IDLE, clear both counters and FIFO pointers, and drive mem_wr_req, busy, done and overflow to 0.
REQ-033 On reset, mem_addr SHALL be mem_map[EEG_INPUT_MEM] and mem_data SHALL be 0.
REQ-034 Reset mid-epoch SHALL abandon the epoch silently, with no done pulse.

Structure
REQ-035 The LoaderState_t enum and the EEG_SAMPLE_OFFSET constant (16'h8000) SHALL be added to the Defines package.
REQ-036 The loader SHALL reuse the existing AdcData_t, IntResAddr_t, IntResDouble_t, DataWidth_t, mem_map, and int_res_format.
REQ-037 The FIFO SHALL be one sub-module, sync_fifo, parameterised by width and depth, with full and empty outputs.

Verification
REQ-038 Scenario 1: reset, start, then 3840 back-to-back samples with mem_wr_gnt tied high.
Required response: address 0 holds 0x8000 ^ sample0, the last write goes to address 3839, done pulses exactly once, overflow stays 0.
REQ-039 Scenario 2: adc_data = 0x0000, 0xFFFF, 0x8000.
Required response: mem_data = 0x8000, 0x7FFF, 0x0000.
REQ-040 Scenario 3: mem_wr_gnt low for 2 cycles while samples arrive every cycle.
Required response: 2 samples are buffered and none are lost.
Scenario 3b: mem_wr_gnt held low for 3 cycles.
Required response: overflow=1, FSM in ERR, mem_wr_req=0.
REQ-041 Scenario 4: rst asserted after 100 samples, then start.
Required response: outputs reset immediately, no done pulse, and the next epoch starts at address 0.
REQ-042 Scenario 5: adc_valid pulses arriving before start and after sample 3840.
Required response: the pulses are not written, and the write count is exactly 3840.
REQ-043 Scenario 6: start pulsed mid-LOAD.
Required response: the counters are unaffected and the epoch completes normally.
